// File: rtl/minibus_pkg.sv
// -----------------------------------------------------------------------------
// minibus_pkg
//   Shared Mini-Bus geometry used by the masters, the arbiter and the slaves.
//   ADDR_WIDTH : byte address width of every Mini-Bus port
//   DATA_WIDTH : data width of every Mini-Bus port
// -----------------------------------------------------------------------------
package minibus_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/minibus_arbiter.sv
// -----------------------------------------------------------------------------
// minibus_arbiter
//   Round-robin arbiter that shares one Mini-Bus slave port between
//   NUM_MASTERS masters. A grant is held for one complete transfer (address
//   phase through ack), and the slave's response is routed back to the owner.
//   A watchdog ends any transfer not acked within TIMEOUT cycles with an error.
//
// Parameters
//   NUM_MASTERS : number of requesting masters (2..8)
//   TIMEOUT     : BUSY cycles without bus_ack before a forced error
//                 completion; 0 disables the watchdog
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   m_wen, m_ren    : per-master write / read request
//   m_addr          : per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_width         : per-master size (00 byte, 01 half, 10 word), 2 bits each
//   m_wdata         : per-master write data, master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_ack           : one-hot completion strobe back to the owner
//   m_err           : error qualifier, meaningful only together with m_ack
//   m_rdata         : read data broadcast to all masters
//   bus_wen/ren     : request forwarded to the slave
//   bus_addr        : forwarded address
//   bus_width       : forwarded size
//   bus_wdata       : forwarded write data
//   bus_sel         : slave select, high for the whole transfer
//   bus_ack/err     : slave completion and error
//   bus_rdata       : slave read data
//   grant           : registered one-hot owner, all-zero when idle
//   busy            : a transfer is in progress
// -----------------------------------------------------------------------------
module minibus_arbiter
  import minibus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_wen,
  input  logic [NUM_MASTERS-1:0]            m_ren,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*2-1:0]          m_width,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              bus_wen,
  output logic                              bus_ren,
  output logic [ADDR_WIDTH-1:0]             bus_addr,
  output logic [1:0]                        bus_width,
  output logic [DATA_WIDTH-1:0]             bus_wdata,
  output logic                              bus_sel,
  input  logic                              bus_ack,
  input  logic                              bus_err,
  input  logic [DATA_WIDTH-1:0]             bus_rdata,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy
);

  // Index width for master numbers, timer width sized to hold TIMEOUT.
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(NUM_MASTERS);
  // With TIMEOUT=0 both constants are 0: the timer never moves and the
  // expiry compare is masked off below.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]             state_reg,  state_next;
  logic [NUM_MASTERS-1:0] grant_reg,  grant_next;
  logic [IDX_W-1:0]       owner_reg,  owner_next;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [TMR_W-1:0]       timer_reg,  timer_next;

  // ---------------------------------------------------------------------------
  // Per-master views of the flattened request buses
  // ---------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] req;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
  logic [1:0]             width_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];
  // cand_idx[k] is the master examined k-th in the round-robin search.
  logic [IDX_W-1:0]       cand_idx  [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      logic [IDX_W:0] cand_sum;

      assign req[gi]       = m_wen[gi] | m_ren[gi];
      assign addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign width_arr[gi] = m_width[gi*2 +: 2];
      assign wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];

      // rr_ptr + gi, wrapped once; one extra bit avoids overflow before wrap.
      assign cand_sum     = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (cand_sum >= N_WIDE) ? IDX_W'(cand_sum - N_WIDE)
                                                 : cand_sum[IDX_W-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after rr_ptr, with wrap-around.
  // ---------------------------------------------------------------------------
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!pick_valid && req[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer completion
  // ---------------------------------------------------------------------------
  logic in_busy;
  logic own_req;
  logic timer_hit;
  logic ack_done;
  logic timeout_done;
  logic abort_done;
  logic xfer_end;
  logic resp_valid;
  logic [IDX_W-1:0] ptr_after;

  assign in_busy   = (state_reg == ST_BUSY);
  assign own_req   = req[owner_reg];
  assign timer_hit = (TIMEOUT != 0) && (timer_reg == TMR_LAST);

  // A slave ack always wins. Without an ack, a master that has withdrawn its
  // request ends the transfer silently, even if the watchdog would fire in
  // the same cycle.
  assign ack_done     = in_busy & bus_ack;
  assign abort_done   = in_busy & ~bus_ack & ~own_req;
  assign timeout_done = in_busy & ~bus_ack & own_req & timer_hit;
  assign xfer_end     = ack_done | timeout_done | abort_done;
  assign resp_valid   = ack_done | timeout_done;

  assign ptr_after = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    timer_next  = timer_reg;

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (pick_valid) begin
          state_next = ST_BUSY;
          owner_next = pick_idx;
          grant_next = NUM_MASTERS'(1) << pick_idx;
        end
      end

      ST_BUSY: begin
        if (xfer_end) begin
          state_next  = ST_IDLE;
          grant_next  = '0;
          rr_ptr_next = ptr_after;
          timer_next  = '0;
        end else if (!bus_ack && (timer_reg != TMR_MAX)) begin
          // Saturating count of cycles spent waiting for the slave.
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      timer_reg  <= timer_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-side outputs: the owner's request, forced to zero when idle.
  // Reset drives state to IDLE at once, so these also read zero under reset.
  // ---------------------------------------------------------------------------
  assign bus_sel   = in_busy;
  assign bus_wen   = in_busy & m_wen[owner_reg];
  assign bus_ren   = in_busy & m_ren[owner_reg];
  assign bus_addr  = in_busy ? addr_arr[owner_reg]  : '0;
  assign bus_width = in_busy ? width_arr[owner_reg] : '0;
  assign bus_wdata = in_busy ? wdata_arr[owner_reg] : '0;

  // ---------------------------------------------------------------------------
  // Master-side outputs: only the owner sees a response, and only in BUSY,
  // so a stray bus_ack while idle is ignored. A watchdog expiry reports an
  // error with zero read data.
  // ---------------------------------------------------------------------------
  assign m_ack   = resp_valid ? grant_reg : '0;
  assign m_err   = ((ack_done & bus_err) | timeout_done) ? grant_reg : '0;
  assign m_rdata = ack_done ? bus_rdata : '0;

  assign grant = grant_reg;
  assign busy  = in_busy;

endmodule
